mpsoc_wb_uart_host: RTL and testbench
=====================================

# mpsoc_wb_uart_host

Wishbone master stage that sits directly upstream of the UART Wishbone slave and drives its 8-bit 16550-style register file. After reset it programs the divisor and line format, then keeps polling LSR. It turns a valid/ready transmit byte stream into THR writes and RBR reads into a valid/ready receive byte stream. This lets a non-bus client, such as a debug console or boot loader, use the UART without software.

## Interface
- DIVISOR, 16'h0036: baud divisor written to DLL/DLM.
- LCR_VAL, 8'h03: line control value for normal operation (8N1); DLAB is forced to 0.
- FCR_VAL, 8'h06: FIFO control value written once (clears both FIFOs, RX trigger level 1).
- TX_BURST, 16: THR writes allowed per observed LSR.THRE=1; legal range 1..16.
- wb_clk_i, input, 1: clock.
- wb_rst_ni, input, 1: reset. One clock; reset is asynchronous and active-low.
- wbm_adr_o, output, 3: register address.
- wbm_dat_o, output, 8: write data.
- wbm_dat_i, input, 8: read data.
- wbm_we_o, output, 1: write enable.
- wbm_stb_o / wbm_cyc_o, output, 1 each: strobe / cycle; always driven equal.
- wbm_sel_o, output, 4: constant 4'b1111.
- wbm_ack_i, input, 1: slave acknowledge.
- tx_data_i, input, 8: byte to transmit.
- tx_valid_i, input, 1: tx_data_i is valid.
- tx_ready_o, output, 1: byte is accepted when valid and ready are both high.
- rx_data_o, output, 8: received byte.
- rx_valid_o, output, 1: rx_data_o is valid; held until consumed.
- rx_ready_i, input, 1: consumer accepts the received byte.
- init_done_o, output, 1: init sequence has completed.
- rx_err_o, output, 1: sticky flag for LSR bits [4:1] (OE/PE/FE/BI); cleared only by reset.

## Operation
**Init sequence.** Fixed writes, in order:
1. LCR = 8'h80 | LCR_VAL
2. adr 0 (DLL) = DIVISOR[7:0]
3. adr 1 (DLM) = DIVISOR[15:8]
4. LCR = LCR_VAL & 8'h7F
5. FCR (adr 2) = FCR_VAL
6. IER (adr 1) = 8'h00

After the ack of the last write, init_done_o rises and stays high.

**States.** INIT → IDLE → {POLL, TXW, RXR} → IDLE.
- Each bus state runs exactly one Wishbone transaction.

**TX holding register.**
- One byte.
- tx_ready_o = init_done_o && holding register empty.
- The handshake loads the register.

**TX credit counter.**
- 5 bits.
- Loaded with TX_BURST when a POLL returns LSR[5]=1.
- Decremented on every THR write ack.
- Never reloaded while nonzero.

**IDLE decision, in priority order.**
1. If the holding register is full, credit > 0, and the last serviced operation was not TXW, or RX is not pending: go to TXW. TXW writes adr 0 with the held byte; on ack the holding register is empty.
2. Otherwise, if rx_pending is set and rx_valid_o = 0: go to RXR. RXR reads adr 0; on ack, rx_data_o is loaded, rx_valid_o is set, and rx_pending is cleared.
3. Otherwise: go to POLL. POLL reads adr 5.
   - rx_pending ← LSR[0].
   - rx_err_o |= |LSR[4:1].
   - If LSR[5]=1, credit ← TX_BURST.

**Fairness.** TX and RX alternate when both are eligible.
- This applies only when TXW or RXR is possible.
- POLL runs only when neither is possible.

**RX output.**
- rx_valid_o clears in the cycle after rx_valid_o && rx_ready_i.
- No RBR read is issued while rx_valid_o = 1, so bytes are never dropped in this block.

## Timing
**Reset values.** While wb_rst_ni=0, all outputs are 0 except wbm_sel_o = 4'b1111.
- This covers wbm_cyc/stb/we/adr/dat, tx_ready_o, rx_data_o, rx_valid_o, init_done_o and rx_err_o.
- State is INIT step 0; credit, holding register and rx_pending are 0.

**Reset mid-operation.** Asserting wb_rst_ni mid-transaction drops wbm_cyc_o/wbm_stb_o asynchronously and aborts the transaction. After release, the full init sequence restarts.

**Wishbone outputs.**
- All outputs are registered.
- cyc/stb rise in the cycle after the state is entered.
- adr, dat and we are stable while stb is high.
- The transaction ends on the first edge where wbm_ack_i=1; cyc/stb are low in the next cycle.
- There is at least one idle cycle (stb=0) between consecutive transactions.
- ack sampled while stb=0 is ignored.

**Latency.**
- First init write: stb is high in cycle 1 after reset release.
- With a zero-wait slave (ack in the cycle after stb), each transaction costs 3 cycles: stb, ack, idle.
- init_done_o rises 1 cycle after the 6th ack.

**Data capture.**
- Read data is captured on the ack edge.
- rx_valid_o is high in the cycle after the RXR ack.
- tx_ready_o falls in the cycle after the handshake and rises in the cycle after the TXW ack.

**Boundaries.**
- Credit saturates at 0; there is no wrap.
- At most TX_BURST THR writes occur between LSR.THRE observations.
- A POLL with LSR[5]=0 leaves the existing credit unchanged.

## Test plan
- **Init.** DIVISOR=16'h0036, defaults. Required: writes (adr, dat) = (3, 83), (0, 36), (1, 00), (3, 03), (2, 06), (1, 00) in order. init_done_o rises 1 cycle after the 6th ack; tx_ready_o=0 before that.
- **Single TX.** Slave LSR=8'h60; send tx_data_i=8'h41. Required: POLL read of adr 5, then a write of adr 0 with 8'h41; tx_ready_o rises again after that ack.
- **Burst limit.** TX_BURST=4, LSR=8'h60 once then 8'h00; stream 6 bytes. Required: exactly 4 THR writes, then only POLLs until LSR returns 8'h60, then the remaining 2 writes.
- **RX with backpressure.** LSR=8'h01, RBR=8'h5A, rx_ready_i=0 for 20 cycles. Required: rx_data_o=8'h5A with rx_valid_o held high, and no further adr-0 read until the handshake.
- **Simultaneous TX/RX and error.** LSR=8'h63 with both directions pending. Required: RXR and TXW alternate, and rx_err_o=1 and stays set.
- **Reset with a slow slave.** Assert wb_rst_ni while stb=1 on a slave with 5 wait states. Required: cyc/stb low immediately, all outputs at reset values, and the init sequence restarts from LCR=8'h83.

Source files
------------

// File: rtl/mpsoc_wb_uart_host.sv
// mpsoc_wb_uart_host: Wishbone master that programs a 16550-style UART,
// then bridges valid/ready TX/RX byte streams onto THR writes / RBR reads.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   wbm_*                        8-bit Wishbone master to the UART slave
//   tx_data_i/valid_i/ready_o    transmit byte stream (sink)
//   rx_data_o/valid_o/ready_i    receive byte stream (source)
//   init_done_o                  init writes have completed
//   rx_err_o                     sticky OE/PE/FE/BI seen in LSR
module mpsoc_wb_uart_host #(
   parameter logic [15:0] DIVISOR  = 16'h0036,
   parameter logic [7:0]  LCR_VAL  = 8'h03,
   parameter logic [7:0]  FCR_VAL  = 8'h06,
   parameter int unsigned TX_BURST = 16
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_ni,
   output logic [2:0] wbm_adr_o,
   output logic [7:0] wbm_dat_o,
   input  logic [7:0] wbm_dat_i,
   output logic       wbm_we_o,
   output logic       wbm_stb_o,
   output logic       wbm_cyc_o,
   output logic [3:0] wbm_sel_o,
   input  logic       wbm_ack_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       init_done_o,
   output logic       rx_err_o
);

   localparam logic [4:0] BURST = 5'(TX_BURST);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_POLL, S_TXW, S_RXR
   } state_t;

   state_t     r_state, w_state_n;
   logic       r_stb, w_stb_n;
   logic [2:0] r_adr, w_adr_n;
   logic [7:0] r_dat, w_dat_n;
   logic       r_we, w_we_n;
   logic [2:0] r_step, w_step_n;
   logic       r_done, w_done_n;

   logic       r_tx_full;
   logic [7:0] r_tx_data;
   logic [4:0] r_credit;
   logic       r_last_tx;
   logic       r_rx_pend;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_rx_err;

   logic       w_ack;
   logic       w_tx_go;
   logic       w_rx_go;
   logic       w_tx_hs;
   logic [2:0] w_init_adr;
   logic [7:0] w_init_dat;

   assign w_ack   = r_stb & wbm_ack_i;
   assign w_rx_go = r_rx_pend & ~r_rx_valid;
   // TX yields to RX only when it was the last serviced op
   assign w_tx_go = r_tx_full & (r_credit != 5'd0)
                  & (~r_last_tx | ~w_rx_go);
   assign w_tx_hs = tx_valid_i & tx_ready_o;

   always_comb begin
      w_init_adr = 3'd1;
      w_init_dat = 8'h00;
      unique case (r_step)
         3'd0: begin w_init_adr = 3'd3; w_init_dat = 8'h80 | LCR_VAL; end
         3'd1: begin w_init_adr = 3'd0; w_init_dat = DIVISOR[7:0];    end
         3'd2: begin w_init_adr = 3'd1; w_init_dat = DIVISOR[15:8];   end
         3'd3: begin w_init_adr = 3'd3; w_init_dat = LCR_VAL & 8'h7F; end
         3'd4: begin w_init_adr = 3'd2; w_init_dat = FCR_VAL;         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      w_stb_n   = r_stb;
      w_adr_n   = r_adr;
      w_dat_n   = r_dat;
      w_we_n    = r_we;
      w_step_n  = r_step;
      w_done_n  = r_done;
      unique case (r_state)
         S_INIT: begin
            if (w_ack) begin
               w_stb_n  = 1'b0;
               w_step_n = r_step + 3'd1;
               if (r_step == 3'd5) begin
                  w_state_n = S_IDLE;
                  w_done_n  = 1'b1;
               end
            end else if (!r_stb) begin
               w_stb_n = 1'b1;
               w_we_n  = 1'b1;
               w_adr_n = w_init_adr;
               w_dat_n = w_init_dat;
            end
         end
         // IDLE is the mandatory gap cycle between transactions
         S_IDLE: begin
            w_stb_n = 1'b1;
            w_dat_n = 8'h00;
            w_we_n  = 1'b0;
            w_adr_n = 3'd0;
            if (w_tx_go) begin
               w_state_n = S_TXW;
               w_dat_n   = r_tx_data;
               w_we_n    = 1'b1;
            end else if (w_rx_go) begin
               w_state_n = S_RXR;
            end else begin
               w_state_n = S_POLL;
               w_adr_n   = 3'd5;
            end
         end
         default: begin
            if (w_ack) begin
               w_stb_n   = 1'b0;
               w_state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= S_INIT;
         r_stb   <= 1'b0;
         r_adr   <= 3'd0;
         r_dat   <= 8'h00;
         r_we    <= 1'b0;
         r_step  <= 3'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_stb   <= w_stb_n;
         r_adr   <= w_adr_n;
         r_dat   <= w_dat_n;
         r_we    <= w_we_n;
         r_step  <= w_step_n;
         r_done  <= w_done_n;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_tx_full  <= 1'b0;
         r_tx_data  <= 8'h00;
         r_credit   <= 5'd0;
         r_last_tx  <= 1'b0;
         r_rx_pend  <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
      end else begin
         if (w_tx_hs) begin
            r_tx_full <= 1'b1;
            r_tx_data <= tx_data_i;
         end
         if (r_rx_valid && rx_ready_i)
            r_rx_valid <= 1'b0;
         if (w_ack) begin
            case (r_state)
               S_TXW: begin
                  r_tx_full <= 1'b0;
                  r_last_tx <= 1'b1;
                  if (r_credit != 5'd0)
                     r_credit <= r_credit - 5'd1;
               end
               S_RXR: begin
                  r_rx_data  <= wbm_dat_i;
                  r_rx_valid <= 1'b1;
                  r_rx_pend  <= 1'b0;
                  r_last_tx  <= 1'b0;
               end
               S_POLL: begin
                  r_rx_pend <= wbm_dat_i[0];
                  r_rx_err  <= r_rx_err | (|wbm_dat_i[4:1]);
                  // credit is only refilled once fully spent
                  if (wbm_dat_i[5] && r_credit == 5'd0)
                     r_credit <= BURST;
               end
               default: ;
            endcase
         end
      end
   end

   assign wbm_adr_o   = r_adr;
   assign wbm_dat_o   = r_dat;
   assign wbm_we_o    = r_we;
   assign wbm_stb_o   = r_stb;
   assign wbm_cyc_o   = r_stb;
   assign wbm_sel_o   = 4'b1111;
   assign tx_ready_o  = r_done & ~r_tx_full;
   assign rx_data_o   = r_rx_data;
   assign rx_valid_o  = r_rx_valid;
   assign init_done_o = r_done;
   assign rx_err_o    = r_rx_err;

endmodule

// File: tb/tb_mpsoc_wb_uart_host.sv
// tb_mpsoc_wb_uart_host: scoreboard bench for mpsoc_wb_uart_host with a
// UART slave model (wait states, LSR, RBR FIFO) and TX_BURST=4.
module tb_mpsoc_wb_uart_host;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] adr;
   logic [7:0] dat_o;
   logic [7:0] dat_i;
   logic       we, stb, cyc;
   logic       ack = 1'b0;
   logic [3:0] sel;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       init_done;
   logic       rx_err;

   int n_chk = 0;
   int n_err = 0;
   int n_wr = 0, n_thr = 0, n_poll = 0, n_rbr = 0;
   int waits = 0, wcnt = 0;
   logic [7:0]  lsr_hi = 8'h00;
   logic        thre_once = 1'b0;
   logic [7:0]  rxmem [16];
   int          rx_wr = 0, rx_rd = 0;
   logic [10:0] exp_wr [$];
   logic [7:0]  exp_rx [$];
   logic        alt_on = 1'b0;
   logic        op_log [$];

   always #5 clk = ~clk;

   assign dat_i = (adr == 3'd5) ? {lsr_hi[7:1], rx_wr != rx_rd}
                                : rxmem[rx_rd[3:0]];

   mpsoc_wb_uart_host #(.TX_BURST(4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wbm_adr_o  (adr),
      .wbm_dat_o  (dat_o),
      .wbm_dat_i  (dat_i),
      .wbm_we_o   (we),
      .wbm_stb_o  (stb),
      .wbm_cyc_o  (cyc),
      .wbm_sel_o  (sel),
      .wbm_ack_i  (ack),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .rx_ready_i (rx_ready),
      .init_done_o(init_done),
      .rx_err_o   (rx_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // slave + monitors: sample after negedge, act after posedge
   always begin : mon
      logic       s_stb, s_ack, s_we, s_cyc;
      logic [2:0] s_adr;
      logic [7:0] s_dat;
      logic [3:0] s_sel;
      @(negedge clk); #1;
      s_stb = stb; s_ack = ack; s_we = we; s_cyc = cyc;
      s_adr = adr; s_dat = dat_o; s_sel = sel;
      if (rx_valid && rx_ready) begin
         if (exp_rx.size() != 0)
            check("rx_data", rx_data, exp_rx.pop_front());
         else
            check("rx_unexp", exp_rx.size(), 1);
      end
      @(posedge clk); #1;
      if (!rst_n) begin
         ack = 1'b0; wcnt = 0;
      end else if (s_stb && s_ack) begin
         ack = 1'b0; wcnt = 0;
         check("cyc", s_cyc, 1);
         check("sel", s_sel, 4'hf);
         if (s_we) begin
            n_wr++;
            if (s_adr == 3'd0) begin
               n_thr++;
               if (alt_on) op_log.push_back(1'b1);
            end
            if (exp_wr.size() != 0)
               check("wr", {s_adr, s_dat}, exp_wr.pop_front());
            else
               check("wr_unexp", exp_wr.size(), 1);
         end else if (s_adr == 3'd5) begin
            n_poll++;
            if (thre_once) begin
               lsr_hi[5] = 1'b0;
               thre_once = 1'b0;
            end
         end else if (s_adr == 3'd0) begin
            n_rbr++;
            if (rx_rd != rx_wr) rx_rd++;
            if (alt_on) op_log.push_back(1'b0);
         end
      end else if (s_stb) begin
         if (wcnt >= waits) ack = 1'b1;
         else wcnt++;
      end
   end

   task automatic rx_push(input logic [7:0] b);
      rxmem[rx_wr[3:0]] = b;
      rx_wr++;
      exp_rx.push_back(b);
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      tx_data = b;
      tx_valid = 1'b1;
      while (!tx_ready && t < 600) begin
         @(negedge clk);
         t++;
      end
      check("tx_hs", tx_ready, 1);
      if (tx_ready) exp_wr.push_back({3'd0, b});
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic rst_chk();
      check("r_stb", stb, 0);
      check("r_cyc", cyc, 0);
      check("r_we", we, 0);
      check("r_adr", adr, 0);
      check("r_dat", dat_o, 0);
      check("r_sel", sel, 4'hf);
      check("r_txrdy", tx_ready, 0);
      check("r_rxdat", rx_data, 0);
      check("r_rxvld", rx_valid, 0);
      check("r_done", init_done, 0);
      check("r_err", rx_err, 0);
   endtask

   task automatic start_init();
      int t = 0;
      int base;
      int rdy_bad = 0;
      logic seen = 1'b0;
      exp_wr.push_back({3'd3, 8'h83});
      exp_wr.push_back({3'd0, 8'h36});
      exp_wr.push_back({3'd1, 8'h00});
      exp_wr.push_back({3'd3, 8'h03});
      exp_wr.push_back({3'd2, 8'h06});
      exp_wr.push_back({3'd1, 8'h00});
      base = n_wr;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("init_lat", stb, 1);
      check("init_first", {adr, dat_o, we}, {3'd3, 8'h83, 1'b1});
      while (t < 600 && !seen) begin
         @(negedge clk);
         t++;
         if (!init_done && tx_ready) rdy_bad++;
         if (init_done || (n_wr - base) >= 6) begin
            seen = 1'b1;
            check("done_lat", init_done, 1);
            check("done_cnt", n_wr - base, 6);
         end
      end
      check("init_to", seen, 1);
      check("rdy_early", rdy_bad, 0);
      check("init_q", exp_wr.size(), 0);
   endtask

   initial begin
      int t, b0, p0, tc, rc, viol;
      logic seen_r;

      repeat (3) @(negedge clk);
      rst_chk();
      start_init();

      // burst: one THRE sighting allows exactly 4 writes
      b0 = n_thr;
      lsr_hi = 8'h60;
      thre_once = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) send(8'(8'hB0 + i));
         end
      join_none
      t = 0;
      while (n_thr < b0 + 4 && t < 400) begin
         @(negedge clk); t++;
      end
      p0 = n_poll;
      repeat (40) @(negedge clk);
      check("burst_cap", n_thr - b0, 4);
      check("burst_poll", n_poll > p0, 1);
      lsr_hi = 8'h60;
      thre_once = 1'b1;
      t = 0;
      while (n_thr < b0 + 6 && t < 400) begin
         @(negedge clk); t++;
      end
      check("burst_rest", n_thr - b0, 6);
      repeat (5) @(negedge clk);
      check("burst_q", exp_wr.size(), 0);

      // single TX
      lsr_hi = 8'h60;
      b0 = n_thr;
      send(8'h41);
      check("txr_fall", tx_ready, 0);
      t = 0;
      while (n_thr == b0 && t < 200) begin
         @(negedge clk); t++;
      end
      check("tx1_cnt", n_thr - b0, 1);
      check("txr_rise", tx_ready, 1);

      // RX with backpressure
      lsr_hi = 8'h00;
      rx_ready = 1'b0;
      rx_push(8'h5A);
      rx_push(8'h77);
      t = 0;
      while (!rx_valid && t < 200) begin
         @(negedge clk); t++;
      end
      check("rx_vld", rx_valid, 1);
      check("rx_dat", rx_data, 8'h5A);
      b0 = n_rbr;
      repeat (20) @(negedge clk);
      check("rx_hold_v", rx_valid, 1);
      check("rx_hold_d", rx_data, 8'h5A);
      check("rx_noread", n_rbr - b0, 0);
      rx_ready = 1'b1;
      @(negedge clk);
      check("rx_clr", rx_valid, 0);
      t = 0;
      while (exp_rx.size() != 0 && t < 200) begin
         @(negedge clk); t++;
      end
      check("rx_drain", exp_rx.size(), 0);
      check("rx_err0", rx_err, 0);

      // both directions busy, LSR error bit set
      lsr_hi = 8'h62;
      op_log.delete();
      alt_on = 1'b1;
      rx_push(8'h11); rx_push(8'h22);
      rx_push(8'h33); rx_push(8'h44);
      fork
         begin
            for (int i = 0; i < 4; i++) send(8'(8'hC1 + i));
         end
      join_none
      b0 = n_thr;
      p0 = n_rbr;
      t = 0;
      while ((n_thr < b0 + 4 || n_rbr < p0 + 4) && t < 2000) begin
         @(negedge clk); t++;
      end
      alt_on = 1'b0;
      check("alt_tx", n_thr - b0, 4);
      check("alt_rx", n_rbr - p0, 4);
      tc = 0; rc = 0; viol = 0; seen_r = 1'b0;
      foreach (op_log[i]) begin
         if (i > 0 && seen_r && tc < 4 && rc < 4 &&
             op_log[i] == op_log[i-1])
            viol++;
         if (op_log[i]) tc++;
         else begin
            rc++;
            seen_r = 1'b1;
         end
      end
      check("alt_seen_r", seen_r, 1);
      check("alt_viol", viol, 0);
      check("err_set", rx_err, 1);
      lsr_hi = 8'h00;
      repeat (30) @(negedge clk);
      check("err_sticky", rx_err, 1);
      check("alt_rxq", exp_rx.size(), 0);
      check("alt_wrq", exp_wr.size(), 0);

      // reset mid-transaction on a slow slave
      waits = 5;
      t = 0;
      while (!stb && t < 100) begin
         @(negedge clk); t++;
      end
      check("rst_stb", stb, 1);
      #2 rst_n = 1'b0;
      #1 rst_chk();
      tx_valid = 1'b0;
      exp_wr.delete();
      repeat (3) @(negedge clk);
      start_init();
      check("rst_err_clr", rx_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
